// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start/data/parity/stop recovery with error flags,
// buffered in a small FIFO drained through a valid/ready handshake.
//
// state    | meaning
// S_IDLE   | waiting for a falling edge on the synchronised line
// S_START  | counting to mid start bit, rejecting glitches
// S_DATA   | sampling DATA_BITS data bits, LSB first
// S_PARITY | sampling the parity bit (only when PARITY != 0)
// S_STOP   | sampling STOP_BITS stop bits, pushing the word at the last one
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rec_data_out,
    output logic                 rec_valid_out,
    input  logic                 rec_ready_in,
    output logic                 parity_err_out,
    output logic                 frame_err_out,
    output logic                 overrun_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_BITS + 2;
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   rxs_q, rxs_d;
    logic                   rxs_prev_q, rxs_prev_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   ovr_q, ovr_d;

    logic                   push;
    logic [EW-1:0]          push_word;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic [EW-1:0]          head;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push       = 1'b0;
        push_word  = {shift_q, perr_q, ferr_q};
        sync1_d    = rxd;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;

        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = CNT_FULL;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_q == LAST_DATA) begin
                        stop_d  = 1'b0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == '0) begin
                    perr_d  = (PARITY == 1) ? ~(^shift_q ^ rxs_q) : (^shift_q ^ rxs_q);
                    cnt_d   = CNT_FULL;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    ferr_d = ferr_q | ~rxs_q;
                    if (stop_q == LAST_STOP) begin
                        // Leave at mid stop bit so a back-to-back start edge is seen.
                        push      = 1'b1;
                        push_word = {shift_q, perr_q, ferr_q | ~rxs_q};
                        state_d   = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                        cnt_d  = CNT_FULL;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = valid_q && rec_ready_in;
        push_ok  = push && (!full || pop);
        ovr_d    = push && full && !pop;
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = push_word;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        // Head view is taken after this cycle's write so a push into an empty FIFO shows next cycle.
        valid_d = (wr_ptr_d != rd_ptr_d);
        head    = valid_d ? mem_d[rd_ptr_d[AW-1:0]] : '0;
        {data_d, perr_out_d, ferr_out_d} = head;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rec_data_out   = data_q;
    assign rec_valid_out  = valid_q;
    assign parity_err_out = perr_out_q;
    assign frame_err_out  = ferr_out_q;
    assign overrun_out    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one instance without parity/1 stop,
// one with even parity/2 stops, both at 4 clocks per bit.
module tb_uart_rx_param;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd0, rxd1, rdy0, rdy1;
    logic [7:0] data0, data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

    int n_pass = 0;
    int n_total = 0;
    int ovr_cnt0 = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .rxd(rxd0),
        .rec_data_out(data0), .rec_valid_out(v0), .rec_ready_in(rdy0),
        .parity_err_out(pe0), .frame_err_out(fe0), .overrun_out(ov0)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd1),
        .rec_data_out(data1), .rec_valid_out(v1), .rec_ready_in(rdy1),
        .parity_err_out(pe1), .frame_err_out(fe1), .overrun_out(ov1)
    );

    always @(negedge clk) if (ov0 === 1'b1) ovr_cnt0++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives bits[0..n-1] one bit period each; returns in the cycle of the last sample.
    task automatic send(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rxd0 = bits[i];
            else          rxd1 = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic pop(input int sel);
        if (sel == 0) rdy0 = 1'b1;
        else          rdy1 = 1'b1;
        @(posedge clk);
        #1;
        rdy0 = (sel == 0) ? 1'b0 : rdy0;
        rdy1 = (sel == 1) ? 1'b0 : rdy1;
    endtask

    function automatic logic [15:0] f0(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] f1(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        return {4'b0, s2, s1, par, d, 1'b0};
    endfunction

    initial begin
        rst  = 1'b0;
        rxd0 = 1'b1;
        rxd1 = 1'b1;
        rdy0 = 1'b1;
        rdy1 = 1'b0;
        cyc(3);
        @(negedge clk);
        chk("rst_data0", data0, 8'h00);
        chk("rst_valid0", v0, 1'b0);
        chk("rst_perr0", pe0, 1'b0);
        chk("rst_ferr0", fe0, 1'b0);
        chk("rst_ovr0", ov0, 1'b0);
        chk("rst_valid1", v1, 1'b0);
        chk("rst_ovr1", ov1, 1'b0);
        cyc(1);
        rst = 1'b1;
        cyc(5);

        // 0xA5, no parity, ready high: valid for exactly the cycle after sample 9
        send(0, f0(8'hA5), 10);
        rxd0 = 1'b1;
        @(negedge clk);
        chk("a5_valid_at_sample9", v0, 1'b0);
        @(negedge clk);
        chk("a5_valid", v0, 1'b1);
        chk("a5_data", data0, 8'hA5);
        chk("a5_perr", pe0, 1'b0);
        chk("a5_ferr", fe0, 1'b0);
        @(negedge clk);
        chk("a5_valid_after_pop", v0, 1'b0);
        chk("a5_data_after_pop", data0, 8'h00);
        cyc(4);

        // even parity: 0x07 with parity 1 is good, with parity 0 is bad
        send(1, f1(8'h07, 1'b1, 1'b1, 1'b1), 12);
        send(1, f1(8'h07, 1'b0, 1'b1, 1'b1), 12);
        cyc(3);
        @(negedge clk);
        chk("par_w1_valid", v1, 1'b1);
        chk("par_w1_data", data1, 8'h07);
        chk("par_w1_perr", pe1, 1'b0);
        chk("par_w1_ferr", fe1, 1'b0);
        pop(1);
        @(negedge clk);
        chk("par_w2_valid", v1, 1'b1);
        chk("par_w2_data", data1, 8'h07);
        chk("par_w2_perr", pe1, 1'b1);
        chk("par_w2_ferr", fe1, 1'b0);
        pop(1);
        @(negedge clk);
        chk("par_empty_valid", v1, 1'b0);
        chk("par_empty_perr", pe1, 1'b0);
        cyc(1);

        // second stop bit low, line held low afterwards (break)
        send(1, f1(8'h3C, 1'b0, 1'b1, 1'b0), 12);
        cyc(2);
        @(negedge clk);
        chk("brk_valid", v1, 1'b1);
        chk("brk_data", data1, 8'h3C);
        chk("brk_ferr", fe1, 1'b1);
        chk("brk_perr", pe1, 1'b0);
        pop(1);
        cyc(60);
        @(negedge clk);
        chk("brk_no_new_frame", v1, 1'b0);
        cyc(1);
        rxd1 = 1'b1;
        cyc(4);
        send(1, f1(8'h81, 1'b0, 1'b1, 1'b1), 12);
        cyc(3);
        @(negedge clk);
        chk("brk_recover_valid", v1, 1'b1);
        chk("brk_recover_data", data1, 8'h81);
        chk("brk_recover_ferr", fe1, 1'b0);
        pop(1);
        @(negedge clk);
        chk("brk_recover_empty", v1, 1'b0);
        cyc(1);

        // five frames back to back into a 4-deep FIFO with ready low
        rdy0 = 1'b0;
        for (int i = 1; i <= 5; i++) send(0, f0(8'(i)), 10);
        @(negedge clk);
        chk("ovr_before", ov0, 1'b0);
        @(negedge clk);
        chk("ovr_pulse", ov0, 1'b1);
        @(negedge clk);
        chk("ovr_after", ov0, 1'b0);
        chk("ovr_pulse_count", ovr_cnt0, 1);
        chk("ovr_full_valid", v0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_%0d", i), data0, i);
            pop(0);
            @(negedge clk);
        end
        chk("drain_empty", v0, 1'b0);
        cyc(1);

        // one-cycle low glitch must not produce a word
        rxd0 = 1'b0;
        cyc(1);
        rxd0 = 1'b1;
        cyc(40);
        @(negedge clk);
        chk("glitch_no_valid", v0, 1'b0);
        chk("glitch_data", data0, 8'h00);
        cyc(1);

        // reset in the middle of data bit 3, then a clean 0x5A
        send(0, f0(8'hFF), 4);
        cyc(1);
        rst  = 1'b0;
        rxd0 = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("midrst_valid", v0, 1'b0);
        chk("midrst_data", data0, 8'h00);
        cyc(1);
        rst = 1'b1;
        cyc(5);
        send(0, f0(8'h5A), 10);
        cyc(3);
        @(negedge clk);
        chk("post_rst_valid", v0, 1'b1);
        chk("post_rst_data", data0, 8'h5A);
        chk("post_rst_perr", pe0, 1'b0);
        chk("post_rst_ferr", fe0, 1'b0);
        pop(0);
        @(negedge clk);
        chk("post_rst_single_word", v0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
